// File: rtl/rsa_defs.sv
// rtl/rsa_defs.sv - shared key width, divider width and FSM state encodings
package rsa_defs;

  localparam int KEY_WIDTH = 16;
  localparam int WIDTH     = 2 * KEY_WIDTH;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    MUL  = 3'd2,
    SQR  = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/division32.sv
// rtl/division32.sv - combinational restoring divider, remainder output
module Division32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remainder
);

  // One extra bit so the shifted partial remainder never overflows.
  logic [WIDTH:0] acc;

  always_comb begin
    acc = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc = {acc[WIDTH-1:0], dividend[i]};
      if (acc >= {1'b0, divisor}) begin
        acc = acc - {1'b0, divisor};
      end
    end
    remainder = acc[WIDTH-1:0];
  end

endmodule

// File: rtl/rsa_modexp16.sv
// rtl/rsa_modexp16.sv - constant-latency square-and-multiply modular exponentiation
module rsa_modexp16 #(
  parameter int KEY_WIDTH = rsa_defs::KEY_WIDTH,
  parameter int WIDTH     = rsa_defs::WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [KEY_WIDTH-1:0] base,
  input  logic [KEY_WIDTH-1:0] exponent,
  input  logic [KEY_WIDTH-1:0] modulus,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [KEY_WIDTH-1:0] result
);
  import rsa_defs::*;

  state_t state, state_nxt;

  logic [KEY_WIDTH-1:0] n_r, e_r, b_r, r_r, result_r;
  logic [4:0]           cnt;
  logic                 err_r;
  logic [WIDTH-1:0]     div_dividend, div_rem;
  logic [KEY_WIDTH-1:0] rem;
  logic                 last_bit;

  // Remainder is always below n, so only the low half carries information.
  logic unused_rem_hi;
  assign unused_rem_hi = &{1'b0, div_rem[WIDTH-1:KEY_WIDTH]};
  assign rem      = div_rem[KEY_WIDTH-1:0];
  assign last_bit = (cnt == 5'(KEY_WIDTH - 1));

  always_comb begin
    div_dividend = '0;
    case (state)
      INIT:    div_dividend = WIDTH'(b_r);
      MUL:     div_dividend = WIDTH'(r_r) * WIDTH'(b_r);
      SQR:     div_dividend = WIDTH'(b_r) * WIDTH'(b_r);
      default: div_dividend = '0;
    endcase
  end

  Division32 #(.WIDTH(WIDTH)) u_div (
    .dividend  (div_dividend),
    .divisor   (WIDTH'(n_r)),
    .remainder (div_rem)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = INIT;
      INIT:    state_nxt = (n_r == '0) ? DONE : MUL;
      MUL:     state_nxt = SQR;
      SQR:     state_nxt = last_bit ? DONE : MUL;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_r      <= '0;
      e_r      <= '0;
      b_r      <= '0;
      r_r      <= '0;
      cnt      <= '0;
      err_r    <= 1'b0;
      result_r <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          n_r   <= modulus;
          e_r   <= exponent;
          b_r   <= base;
          err_r <= 1'b0;
        end
        INIT: if (n_r == '0) begin
          err_r    <= 1'b1;
          result_r <= '0;
        end else begin
          b_r <= rem;
          r_r <= (n_r == KEY_WIDTH'(1)) ? '0 : KEY_WIDTH'(1);
          cnt <= '0;
        end
        MUL: if (e_r[0]) r_r <= rem;
        SQR: begin
          b_r <= rem;
          e_r <= e_r >> 1;
          cnt <= cnt + 5'd1;
          // Result is loaded on the way into DONE so it is valid alongside done.
          if (last_bit) result_r <= r_r;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state == INIT) || (state == MUL) || (state == SQR);
  assign done   = (state == DONE);
  assign err    = err_r;
  assign result = result_r;

endmodule

// File: tb/tb_rsa_modexp16.sv
// tb/tb_rsa_modexp16.sv - directed self-checking bench for rsa_modexp16
module tb_rsa_modexp16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base = '0, exponent = '0, modulus = '0;
  logic        busy, done, err;
  logic [15:0] result;

  int passed = 0;
  int total  = 0;
  int cyc;
  int done_cnt;
  int done_cyc;

  always #5 clk = ~clk;

  rsa_modexp16 dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base     (base),
    .exponent (exponent),
    .modulus  (modulus),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .result   (result)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Returns the cycle (1 = INIT) in which done was seen, or 40 on timeout.
  task automatic run_job(input logic [15:0] b, input logic [15:0] e, input logic [15:0] n,
                         output int c);
    @(negedge clk);
    base = b; exponent = e; modulus = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 1;
    check("busy_in_init", busy, 1);
    while (!done && c < 40) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic expect_job(input string tag, input logic [15:0] b, input logic [15:0] e,
                            input logic [15:0] n, input logic [15:0] res);
    run_job(b, e, n, cyc);
    check({tag, "_cycle"}, cyc, 34);
    check({tag, "_result"}, result, res);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_result", result, 0);
    rst = 1'b0;

    run_job(16'd4, 16'd13, 16'd497, cyc);
    check("j1_cycle", cyc, 34);
    check("j1_result", result, 445);
    check("j1_err", err, 0);
    check("j1_busy_in_done", busy, 0);
    @(negedge clk);
    check("j1_done_one_pulse", done, 0);
    check("j1_result_held", result, 445);

    expect_job("rsa_enc", 16'd65, 16'd17, 16'd3233, 16'd2790);
    expect_job("rsa_dec", 16'd2790, 16'd2753, 16'd3233, 16'd65);
    expect_job("base_ge_n", 16'd1000, 16'd1, 16'd7, 16'd6);
    expect_job("exp_zero", 16'd7, 16'd0, 16'd13, 16'd1);
    expect_job("n_one", 16'd5, 16'd3, 16'd1, 16'd0);

    run_job(16'd9, 16'd5, 16'd0, cyc);
    check("nzero_cycle", cyc, 2);
    check("nzero_err", err, 1);
    check("nzero_result", result, 0);

    expect_job("err_cleared", 16'd3, 16'd4, 16'd10, 16'd1);

    // Stray starts in cycles 5 and 34 must not disturb or retrigger the job.
    @(negedge clk);
    base = 16'd4; exponent = 16'd13; modulus = 16'd497; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0;
    done_cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (c == 36) check("stray_busy_after", busy, 0);
      if (c == 5 || c == 34) begin
        base = 16'd2; exponent = 16'd2; modulus = 16'd5; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    check("stray_done_count", done_cnt, 1);
    check("stray_done_cycle", done_cyc, 34);
    check("stray_result", result, 445);

    // Reset in cycle 10 of a job.
    @(negedge clk);
    base = 16'd65; exponent = 16'd17; modulus = 16'd3233; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 10; c++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_result", result, 0);
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    check("mid_rst_no_done", done_cnt, 0);
    expect_job("after_rst", 16'd2790, 16'd2753, 16'd3233, 16'd65);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
